// File: rtl/boot_memory_pkg.sv
// Shared definitions for the boot memory: word width default, byte-lane width
// and the loader/run state encoding.
package boot_memory_pkg;

    localparam int unsigned WORD_LEN_DEFAULT = 32;
    localparam int unsigned BYTE_W           = 8;
    localparam int unsigned BYTES_PER_WORD   = WORD_LEN_DEFAULT / BYTE_W;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Bit offset of a byte lane inside a word (lane * 8).
    function automatic logic [4:0] lane_shift(input logic [1:0] lane);
        return {lane, 3'b000};
    endfunction

endpackage

// File: rtl/mem_loader.sv
// Byte-serial program loader: assembles little-endian words, issues memory
// writes and releases the core reset once the last byte has arrived.
module mem_loader
    import boot_memory_pkg::*;
#(
    parameter int unsigned WORD_LEN  = WORD_LEN_DEFAULT,
    parameter int unsigned ADDR_BITS = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_valid_i,
    input  logic [BYTE_W-1:0]    load_data_i,
    input  logic                 load_last_i,
    output logic                 load_ready_o,
    output logic                 load_done_o,
    output logic                 load_error_o,
    output logic                 core_rst_n_o,
    output state_e               state_o,
    output logic                 wr_en_o,
    output logic [ADDR_BITS-1:0] wr_addr_o,
    output logic [WORD_LEN-1:0]  wr_data_o
);

    state_e                 state_q;
    logic [1:0]             byte_cnt_q;
    logic [ADDR_BITS-1:0]   word_addr_q;
    logic                   carry_q;
    logic [WORD_LEN-1:0]    word_buf_q;
    logic                   error_q;
    logic                   ready_q;
    logic                   done_q;
    logic                   core_rst_n_q;

    logic                   xfer;
    logic                   word_due;
    logic [WORD_LEN-1:0]    merged;

    always_comb begin
        xfer     = load_valid_i && ready_q && (state_q == ST_LOAD);
        // word_buf is cleared after each word, so unfilled upper lanes read as zero.
        merged   = word_buf_q | (WORD_LEN'(load_data_i) << lane_shift(byte_cnt_q));
        word_due = xfer && ((byte_cnt_q == 2'd3) || load_last_i);
        wr_en_o  = word_due && !carry_q && !rst_i;
        wr_addr_o = word_addr_q;
        wr_data_o = merged;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_LOAD;
            byte_cnt_q   <= 2'd0;
            word_addr_q  <= '0;
            carry_q      <= 1'b0;
            word_buf_q   <= '0;
            error_q      <= 1'b0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else if (xfer) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            word_buf_q <= word_due ? '0 : merged;
            if (word_due) begin
                if (carry_q) begin
                    error_q <= 1'b1;
                end else begin
                    {carry_q, word_addr_q} <= {1'b0, word_addr_q} + (ADDR_BITS + 1)'(1);
                end
            end
            if (load_last_i) begin
                state_q      <= ST_RUN;
                byte_cnt_q   <= 2'd0;
                ready_q      <= 1'b0;
                done_q       <= 1'b1;
                core_rst_n_q <= 1'b1;
            end
        end
    end

    assign load_ready_o = ready_q;
    assign load_done_o  = done_q;
    assign load_error_o = error_q;
    assign core_rst_n_o = core_rst_n_q;
    assign state_o      = state_q;

endmodule

// File: rtl/boot_memory.sv
// Word-addressed memory shared by the core's fetch and load/store ports,
// filled by a byte-serial loader while the core is held in reset.
module boot_memory
    import boot_memory_pkg::*;
#(
    parameter int unsigned WORD_LEN  = WORD_LEN_DEFAULT,
    parameter int unsigned ADDR_BITS = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_LEN-1:0] memory_i_addr,
    output logic [WORD_LEN-1:0] memory_inst,
    input  logic [WORD_LEN-1:0] memory_d_addr,
    output logic [WORD_LEN-1:0] memory_rdata,
    input  logic                memory_wen,
    input  logic [WORD_LEN-1:0] memory_wdata,
    input  logic                load_valid,
    input  logic [BYTE_W-1:0]   load_data,
    input  logic                load_last,
    output logic                load_ready,
    output logic                load_done,
    output logic                load_error,
    output logic                core_rst_n
);

    localparam int unsigned Depth = 2 ** ADDR_BITS;

    logic [WORD_LEN-1:0]  mem_q [Depth];

    state_e               state;
    logic                 ld_wr_en;
    logic [ADDR_BITS-1:0] ld_wr_addr;
    logic [WORD_LEN-1:0]  ld_wr_data;

    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_waddr;
    logic [WORD_LEN-1:0]  mem_wdata;

    logic [ADDR_BITS-1:0] i_idx;
    logic [ADDR_BITS-1:0] d_idx;
    logic                 unused_addr_bits;

    mem_loader #(
        .WORD_LEN  (WORD_LEN),
        .ADDR_BITS (ADDR_BITS)
    ) u_loader (
        .clk_i        (clk),
        .rst_i        (rst),
        .load_valid_i (load_valid),
        .load_data_i  (load_data),
        .load_last_i  (load_last),
        .load_ready_o (load_ready),
        .load_done_o  (load_done),
        .load_error_o (load_error),
        .core_rst_n_o (core_rst_n),
        .state_o      (state),
        .wr_en_o      (ld_wr_en),
        .wr_addr_o    (ld_wr_addr),
        .wr_data_o    (ld_wr_data)
    );

    // Byte offset and bits above the array depth are dropped: word access, wrapping.
    assign i_idx = memory_i_addr[ADDR_BITS+1:2];
    assign d_idx = memory_d_addr[ADDR_BITS+1:2];
    assign unused_addr_bits = ^{memory_i_addr[WORD_LEN-1:ADDR_BITS+2], memory_i_addr[1:0],
                                memory_d_addr[WORD_LEN-1:ADDR_BITS+2], memory_d_addr[1:0]};

    always_comb begin
        if (state == ST_RUN) begin
            mem_we    = memory_wen && !rst;
            mem_waddr = d_idx;
            mem_wdata = memory_wdata;
        end else begin
            mem_we    = ld_wr_en;
            mem_waddr = ld_wr_addr;
            mem_wdata = ld_wr_data;
        end
    end

    // Contents deliberately survive rst so a reload can be partial.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        memory_inst  = '0;
        memory_rdata = '0;
        if (state == ST_RUN) begin
            memory_inst  = mem_q[i_idx];
            memory_rdata = mem_q[d_idx];
        end
    end

endmodule

// File: tb/tb_boot_memory.sv
// Self-checking bench for boot_memory: directed load/run scenarios plus random
// core traffic compared against a word-array reference model.
module tb_boot_memory;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (ADDR_BITS = 12)
    logic        rst = 1'b1;
    logic [31:0] i_addr = '0, d_addr = '0, wdata = '0;
    logic [31:0] inst, rdata;
    logic        wen = 1'b0, lv = 1'b0, ll = 1'b0;
    logic [7:0]  ld = '0;
    logic        lr, ldone, lerr, crn;

    // Small instance (ADDR_BITS = 2) for overflow
    logic        s_rst = 1'b1;
    logic [31:0] s_i_addr = '0, s_d_addr = '0;
    logic [31:0] s_inst, s_rdata;
    logic        s_lv = 1'b0, s_ll = 1'b0;
    logic [7:0]  s_ld = '0;
    logic        s_lr, s_ldone, s_lerr, s_crn;

    boot_memory dut (
        .clk           (clk),
        .rst           (rst),
        .memory_i_addr (i_addr),
        .memory_inst   (inst),
        .memory_d_addr (d_addr),
        .memory_rdata  (rdata),
        .memory_wen    (wen),
        .memory_wdata  (wdata),
        .load_valid    (lv),
        .load_data     (ld),
        .load_last     (ll),
        .load_ready    (lr),
        .load_done     (ldone),
        .load_error    (lerr),
        .core_rst_n    (crn)
    );

    boot_memory #(.WORD_LEN(32), .ADDR_BITS(2)) dut_s (
        .clk           (clk),
        .rst           (s_rst),
        .memory_i_addr (s_i_addr),
        .memory_inst   (s_inst),
        .memory_d_addr (s_d_addr),
        .memory_rdata  (s_rdata),
        .memory_wen    (1'b0),
        .memory_wdata  (32'h0),
        .load_valid    (s_lv),
        .load_data     (s_ld),
        .load_last     (s_ll),
        .load_ready    (s_lr),
        .load_done     (s_ldone),
        .load_error    (s_lerr),
        .core_rst_n    (s_crn)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] ref_mem [0:4095];
    logic [7:0]  img_q [$];
    int          ii, dd;
    logic [31:0] rw;
    logic        rwe;
    logic [31:0] exp_w;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        lv = 1'b1;
        ld = b;
        ll = last;
        cyc();
        lv = 1'b0;
        ll = 1'b0;
    endtask

    task automatic s_send(input logic [7:0] b, input logic last);
        s_lv = 1'b1;
        s_ld = b;
        s_ll = last;
        cyc();
        s_lv = 1'b0;
        s_ll = 1'b0;
    endtask

    // Sends img_q as one image and folds it into the reference model.
    task automatic load_image();
        for (int i = 0; i < img_q.size(); i++) begin
            if (i == img_q.size() - 1) begin
                chk("done_before_last", {31'b0, ldone}, 32'd0);
                chk("crn_before_last", {31'b0, crn}, 32'd0);
            end
            send(img_q[i], i == img_q.size() - 1);
            if (i % 4 == 0) ref_mem[i / 4] = 32'h0;
            ref_mem[i / 4] = ref_mem[i / 4] | (32'(img_q[i]) << (8 * (i % 4)));
        end
        chk("done_after_last", {31'b0, ldone}, 32'd1);
        chk("crn_after_last", {31'b0, crn}, 32'd1);
        chk("ready_after_last", {31'b0, lr}, 32'd0);
    endtask

    // Reads one word through both ports with junk in the ignored address bits.
    task automatic check_word(input string tag, input int idx, input logic [31:0] exp);
        wen    = 1'b0;
        i_addr = ($urandom & 32'hFFFF_C000) | (32'(idx) << 2) | ($urandom & 32'h3);
        d_addr = ($urandom & 32'hFFFF_C000) | (32'(idx) << 2) | ($urandom & 32'h3);
        #1;
        chk({tag, "_inst"}, inst, exp);
        chk({tag, "_rdata"}, rdata, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'b0, lr}, 32'd1);
        chk({tag, "_done"}, {31'b0, ldone}, 32'd0);
        chk({tag, "_err"}, {31'b0, lerr}, 32'd0);
        chk({tag, "_crn"}, {31'b0, crn}, 32'd0);
    endtask

    initial begin
        // Reset state
        cyc();
        cyc();
        check_reset_outputs("rst");
        rst = 1'b0;
        #1;
        chk("rst_inst", inst, 32'h0);
        chk("rst_rdata", rdata, 32'h0);

        // Core store during LOAD must be ignored; reads stay zero
        wen = 1'b1;
        d_addr = 32'h0;
        wdata = 32'hDEAD_BEEF;
        i_addr = 32'h0;
        send(8'h13, 1'b0);
        #1;
        chk("load_inst_zero", inst, 32'h0);
        chk("load_rdata_zero", rdata, 32'h0);
        img_q = '{8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        ref_mem[0] = 32'h13;
        for (int i = 0; i < 7; i++) begin
            send(img_q[i], i == 6);
            if (i == 5) begin
                chk("crn_before_last", {31'b0, crn}, 32'd0);
            end
        end
        wen = 1'b0;
        #1;
        chk("prog_done", {31'b0, ldone}, 32'd1);
        chk("prog_crn", {31'b0, crn}, 32'd1);
        chk("prog_err", {31'b0, lerr}, 32'd0);
        i_addr = 32'h4;
        #1;
        chk("fetch_4", inst, 32'h0010_0093);
        check_word("prog_w0", 0, 32'h0000_0013);
        check_word("prog_w1", 1, 32'h0010_0093);
        ref_mem[1] = 32'h0010_0093;

        // RUN store with same-cycle read-old / next-cycle read-new
        wen = 1'b1;
        d_addr = 32'h10;
        wdata = 32'h1111_1111;
        cyc();
        wdata = 32'hCAFE_BABE;
        i_addr = 32'h10;
        #1;
        chk("st_same_rdata", rdata, 32'h1111_1111);
        chk("st_same_inst", inst, 32'h1111_1111);
        cyc();
        wen = 1'b0;
        #1;
        chk("st_next_rdata", rdata, 32'hCAFE_BABE);
        d_addr = 32'h11;
        #1;
        chk("st_unaligned", rdata, 32'hCAFE_BABE);
        ref_mem[4] = 32'hCAFE_BABE;

        // Loader bytes in RUN are refused
        chk("run_ready", {31'b0, lr}, 32'd0);
        send(8'h55, 1'b1);
        check_word("run_ignore_w0", 0, ref_mem[0]);

        // Reset during RUN, memory retained, then 1-byte reload
        rst = 1'b1;
        cyc();
        check_reset_outputs("rerst");
        rst = 1'b0;
        img_q = '{8'hAB};
        load_image();
        check_word("reload_w0", 0, ref_mem[0]);
        check_word("reload_w1", 1, ref_mem[1]);
        check_word("reload_w4", 4, ref_mem[4]);

        // Partial trailing word
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        img_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        load_image();
        check_word("part_w0", 0, 32'h0403_0201);
        check_word("part_w1", 1, 32'h0000_0005);

        // Random full image then random core traffic against the model
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        img_q = {};
        for (int i = 0; i < 64; i++) img_q.push_back(8'($urandom));
        load_image();
        for (int w = 0; w < 16; w++) check_word("rimg", w, ref_mem[w]);
        for (int k = 0; k < 150; k++) begin
            ii  = int'($urandom_range(15));
            dd  = ($urandom_range(3) == 0) ? ii : int'($urandom_range(15));
            rw  = $urandom;
            rwe = 1'($urandom_range(1));
            i_addr = ($urandom & 32'hFFFF_C003) | (32'(ii) << 2);
            d_addr = ($urandom & 32'hFFFF_C003) | (32'(dd) << 2);
            wdata  = rw;
            wen    = rwe;
            #1;
            chk("rnd_inst", inst, ref_mem[ii]);
            chk("rnd_rdata", rdata, ref_mem[dd]);
            cyc();
            if (rwe) ref_mem[dd] = rw;
        end
        wen = 1'b0;
        for (int w = 0; w < 16; w++) check_word("rnd_final", w, ref_mem[w]);

        // Overflow on a 4-word memory
        cyc();
        s_rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_send(8'(i + 1), i == 19);
            if (i == 15 || i == 18) chk("s_err_early", {31'b0, s_lerr}, 32'd0);
        end
        chk("s_err", {31'b0, s_lerr}, 32'd1);
        chk("s_done", {31'b0, s_ldone}, 32'd1);
        chk("s_crn", {31'b0, s_crn}, 32'd1);
        for (int w = 0; w < 4; w++) begin
            exp_w = {8'(4 * w + 4), 8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1)};
            s_i_addr = ($urandom & 32'hFFFF_FFF0) | (32'(w) << 2);
            s_d_addr = ($urandom & 32'hFFFF_FFF3) | (32'(w) << 2);
            #1;
            chk("s_inst", s_inst, exp_w);
            chk("s_rdata", s_rdata, exp_w);
        end
        s_rst = 1'b1;
        cyc();
        chk("s_rst_err", {31'b0, s_lerr}, 32'd0);
        chk("s_rst_ready", {31'b0, s_lr}, 32'd1);
        s_rst = 1'b0;
        s_send(8'h77, 1'b1);
        s_i_addr = 32'h0;
        s_d_addr = 32'h4;
        #1;
        chk("s_reload_w0", s_inst, 32'h0000_0077);
        chk("s_reload_w1", s_rdata, 32'h0807_0605);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
